// File: rtl/vx_ifetch_stage.sv
// Instruction fetch responder: forwards scheduler fetches to the icache, tracks one
// outstanding fetch per warp, and pairs icache words with stored request metadata.
module vx_ifetch_stage #(
  parameter int CORE_ID     = 0,
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int UUID_BITS   = 44,
  localparam int NW_BITS    = $clog2(NUM_WARPS)
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   ifetch_req_valid,
  output logic                   ifetch_req_ready,
  input  logic [NW_BITS-1:0]     ifetch_req_wid,
  input  logic [31:0]            ifetch_req_PC,
  input  logic [NUM_THREADS-1:0] ifetch_req_tmask,
  input  logic [UUID_BITS-1:0]   ifetch_req_uuid,

  output logic                   icache_req_valid,
  input  logic                   icache_req_ready,
  output logic [29:0]            icache_req_addr,
  output logic [NW_BITS-1:0]     icache_req_tag,

  input  logic                   icache_rsp_valid,
  output logic                   icache_rsp_ready,
  input  logic [31:0]            icache_rsp_data,
  input  logic [NW_BITS-1:0]     icache_rsp_tag,

  output logic                   ifetch_rsp_valid,
  input  logic                   ifetch_rsp_ready,
  output logic [NW_BITS-1:0]     ifetch_rsp_wid,
  output logic [31:0]            ifetch_rsp_PC,
  output logic [NUM_THREADS-1:0] ifetch_rsp_tmask,
  output logic [UUID_BITS-1:0]   ifetch_rsp_uuid,
  output logic [31:0]            ifetch_rsp_data,

  output logic [NW_BITS:0]       pending_count,
  output logic                   busy
);

  // Every channel uses valid/ready: a transfer happens on a rising clock edge where
  // both are high; a producer holds valid and payload stable until that transfer.

  if (CORE_ID < 0) begin : g_core_id_unused
  end

  logic                   req_fire;
  logic                   rsp_fire;
  logic [NUM_WARPS-1:0]   pending_mask;
  logic [NUM_WARPS-1:0]   pending_mask_next;
  logic [NW_BITS:0]       count_sum;

  logic [31:0]            pc_tab    [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_tab [NUM_WARPS];
  logic [UUID_BITS-1:0]   uuid_tab  [NUM_WARPS];

  assign icache_req_valid = ifetch_req_valid;
  assign ifetch_req_ready = icache_req_ready;
  assign icache_req_addr  = ifetch_req_PC[31:2];
  assign icache_req_tag   = ifetch_req_wid;

  assign req_fire = ifetch_req_valid & icache_req_ready;

  assign icache_rsp_ready = !ifetch_rsp_valid | ifetch_rsp_ready;
  assign rsp_fire         = icache_rsp_valid & icache_rsp_ready;

  // Clear before set so a same-warp reissue in the retiring cycle stays pending.
  always_comb begin
    pending_mask_next = pending_mask;
    if (rsp_fire) pending_mask_next[icache_rsp_tag] = 1'b0;
    if (req_fire) pending_mask_next[ifetch_req_wid] = 1'b1;
  end

  always_comb begin
    count_sum = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      count_sum = count_sum + (NW_BITS+1)'(pending_mask[i]);
    end
  end

  assign pending_count = count_sum;
  assign busy          = (|pending_mask) | ifetch_rsp_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_mask     <= '0;
      ifetch_rsp_valid <= 1'b0;
    end else begin
      pending_mask <= pending_mask_next;
      if (rsp_fire) begin
        ifetch_rsp_valid <= 1'b1;
      end else if (ifetch_rsp_ready) begin
        ifetch_rsp_valid <= 1'b0;
      end
    end
  end

  // Payload storage is unreset; the response read sees the table before this cycle's write.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pc_tab[ifetch_req_wid]    <= ifetch_req_PC;
      tmask_tab[ifetch_req_wid] <= ifetch_req_tmask;
      uuid_tab[ifetch_req_wid]  <= ifetch_req_uuid;
    end
    if (rsp_fire) begin
      ifetch_rsp_wid   <= icache_rsp_tag;
      ifetch_rsp_PC    <= pc_tab[icache_rsp_tag];
      ifetch_rsp_tmask <= tmask_tab[icache_rsp_tag];
      ifetch_rsp_uuid  <= uuid_tab[icache_rsp_tag];
      ifetch_rsp_data  <= icache_rsp_data;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (req_fire) begin
        assert (!pending_mask[ifetch_req_wid] || (rsp_fire && icache_rsp_tag == ifetch_req_wid))
          else $error("ifetch: second outstanding fetch for warp %0d", ifetch_req_wid);
        assert (ifetch_req_PC[1:0] == 2'b00)
          else $error("ifetch: misaligned PC %h", ifetch_req_PC);
      end
      if (rsp_fire) begin
        assert (pending_mask[icache_rsp_tag])
          else $error("ifetch: response for warp %0d with no fetch pending", icache_rsp_tag);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_ifetch_stage.sv
// Directed bench for vx_ifetch_stage: the bench plays scheduler, icache and decode,
// and a scoreboard checks every decode-side transfer against expected pairings.
module tb_vx_ifetch_stage;

  localparam int NUM_WARPS   = 4;
  localparam int NUM_THREADS = 4;
  localparam int UUID_BITS   = 44;
  localparam int NW_BITS     = 2;
  localparam int W           = NW_BITS + 32 + NUM_THREADS + UUID_BITS + 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   ifetch_req_valid;
  logic                   ifetch_req_ready;
  logic [NW_BITS-1:0]     ifetch_req_wid;
  logic [31:0]            ifetch_req_PC;
  logic [NUM_THREADS-1:0] ifetch_req_tmask;
  logic [UUID_BITS-1:0]   ifetch_req_uuid;
  logic                   icache_req_valid;
  logic                   icache_req_ready;
  logic [29:0]            icache_req_addr;
  logic [NW_BITS-1:0]     icache_req_tag;
  logic                   icache_rsp_valid;
  logic                   icache_rsp_ready;
  logic [31:0]            icache_rsp_data;
  logic [NW_BITS-1:0]     icache_rsp_tag;
  logic                   ifetch_rsp_valid;
  logic                   ifetch_rsp_ready;
  logic [NW_BITS-1:0]     ifetch_rsp_wid;
  logic [31:0]            ifetch_rsp_PC;
  logic [NUM_THREADS-1:0] ifetch_rsp_tmask;
  logic [UUID_BITS-1:0]   ifetch_rsp_uuid;
  logic [31:0]            ifetch_rsp_data;
  logic [NW_BITS:0]       pending_count;
  logic                   busy;

  vx_ifetch_stage #(
    .CORE_ID(0), .NUM_WARPS(NUM_WARPS), .NUM_THREADS(NUM_THREADS), .UUID_BITS(UUID_BITS)
  ) dut (
    .clk(clk), .reset(reset),
    .ifetch_req_valid(ifetch_req_valid), .ifetch_req_ready(ifetch_req_ready),
    .ifetch_req_wid(ifetch_req_wid), .ifetch_req_PC(ifetch_req_PC),
    .ifetch_req_tmask(ifetch_req_tmask), .ifetch_req_uuid(ifetch_req_uuid),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_addr(icache_req_addr), .icache_req_tag(icache_req_tag),
    .icache_rsp_valid(icache_rsp_valid), .icache_rsp_ready(icache_rsp_ready),
    .icache_rsp_data(icache_rsp_data), .icache_rsp_tag(icache_rsp_tag),
    .ifetch_rsp_valid(ifetch_rsp_valid), .ifetch_rsp_ready(ifetch_rsp_ready),
    .ifetch_rsp_wid(ifetch_rsp_wid), .ifetch_rsp_PC(ifetch_rsp_PC),
    .ifetch_rsp_tmask(ifetch_rsp_tmask), .ifetch_rsp_uuid(ifetch_rsp_uuid),
    .ifetch_rsp_data(ifetch_rsp_data),
    .pending_count(pending_count), .busy(busy)
  );

  // Clock/reset
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [W-1:0] exp_q[$];

  // Metadata the bench believes each warp's outstanding fetch carries.
  logic [31:0]            m_pc    [NUM_WARPS];
  logic [NUM_THREADS-1:0] m_tmask [NUM_WARPS];
  logic [UUID_BITS-1:0]   m_uuid  [NUM_WARPS];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: one accepted request lasting a single cycle.
  task automatic issue_req(input int wid, input logic [31:0] pc,
                           input logic [3:0] tm, input logic [43:0] uuid);
    ifetch_req_valid = 1'b1;
    ifetch_req_wid   = NW_BITS'(wid);
    ifetch_req_PC    = pc;
    ifetch_req_tmask = tm;
    ifetch_req_uuid  = uuid;
    icache_req_ready = 1'b1;
    @(negedge clk);
    check("req_ready", 128'(ifetch_req_ready), 128'd1);
    check("icache_addr", 128'(icache_req_addr), 128'(pc >> 2));
    check("icache_tag", 128'(icache_req_tag), 128'(wid));
    m_pc[wid]    = pc;
    m_tmask[wid] = tm;
    m_uuid[wid]  = uuid;
    step();
    ifetch_req_valid = 1'b0;
  endtask

  // Driver: offer an icache response until accepted (bounded).
  task automatic offer_rsp(input int tag, input logic [31:0] data);
    bit fired = 0;
    icache_rsp_valid = 1'b1;
    icache_rsp_tag   = NW_BITS'(tag);
    icache_rsp_data  = data;
    for (int c = 0; c < 20 && !fired; c++) begin
      @(negedge clk);
      if (icache_rsp_ready) begin
        exp_q.push_back({NW_BITS'(tag), m_pc[tag], m_tmask[tag], m_uuid[tag], data});
        fired = 1;
      end
      step();
    end
    icache_rsp_valid = 1'b0;
    if (!fired) check("rsp_accept_timeout", 128'd0, 128'd1);
  endtask

  // Driver: response and a new request for the same warp in one cycle.
  task automatic req_and_rsp(input int wid, input logic [31:0] pc, input logic [3:0] tm,
                             input logic [43:0] uuid, input logic [31:0] data);
    ifetch_req_valid = 1'b1;
    ifetch_req_wid   = NW_BITS'(wid);
    ifetch_req_PC    = pc;
    ifetch_req_tmask = tm;
    ifetch_req_uuid  = uuid;
    icache_req_ready = 1'b1;
    icache_rsp_valid = 1'b1;
    icache_rsp_tag   = NW_BITS'(wid);
    icache_rsp_data  = data;
    @(negedge clk);
    check("same_cycle_rsp_ready", 128'(icache_rsp_ready), 128'd1);
    exp_q.push_back({NW_BITS'(wid), m_pc[wid], m_tmask[wid], m_uuid[wid], data});
    m_pc[wid]    = pc;
    m_tmask[wid] = tm;
    m_uuid[wid]  = uuid;
    step();
    ifetch_req_valid = 1'b0;
    icache_rsp_valid = 1'b0;
  endtask

  // Scoreboard monitor: compares every decode-side transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && ifetch_rsp_valid && ifetch_rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 128'({ifetch_rsp_wid, ifetch_rsp_data}), 128'd0);
        end else begin
          check("ifetch_rsp", 128'({ifetch_rsp_wid, ifetch_rsp_PC, ifetch_rsp_tmask,
                                    ifetch_rsp_uuid, ifetch_rsp_data}),
                128'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    ifetch_req_valid = 1'b0; ifetch_req_wid = '0; ifetch_req_PC = '0;
    ifetch_req_tmask = '0; ifetch_req_uuid = '0;
    icache_req_ready = 1'b1;
    icache_rsp_valid = 1'b0; icache_rsp_data = '0; icache_rsp_tag = '0;
    ifetch_rsp_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    check("reset_valid", 128'(ifetch_rsp_valid), 128'd0);
    check("reset_pending", 128'(pending_count), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_rsp_ready", 128'(icache_rsp_ready), 128'd1);
    step();

    // Single fetch
    issue_req(1, 32'h8000_0004, 4'b0011, 44'h0AB_CDEF_0001);
    check("single_pending1", 128'(pending_count), 128'd1);
    offer_rsp(1, 32'hDEAD_BEEF);
    check("single_latency", 128'(ifetch_rsp_valid), 128'd1);
    check("single_pending0", 128'(pending_count), 128'd0);
    step();

    // Out-of-order returns
    issue_req(0, 32'h0000_1000, 4'b0001, 44'h000_0000_0100);
    issue_req(1, 32'h0000_2004, 4'b0010, 44'h000_0000_0101);
    issue_req(2, 32'h0000_3008, 4'b0100, 44'h000_0000_0102);
    issue_req(3, 32'h0000_400C, 4'b1000, 44'h000_0000_0103);
    check("ooo_peak", 128'(pending_count), 128'd4);
    offer_rsp(2, 32'h2222_2222);
    offer_rsp(0, 32'h0000_0000);
    offer_rsp(3, 32'h3333_3333);
    offer_rsp(1, 32'h1111_1111);
    check("ooo_drained", 128'(pending_count), 128'd0);
    step();
    step();

    // Output stall with a second response waiting
    ifetch_rsp_ready = 1'b0;
    issue_req(0, 32'h0000_5000, 4'b1111, 44'h000_0000_0200);
    issue_req(1, 32'h0000_6000, 4'b0101, 44'h000_0000_0201);
    offer_rsp(0, 32'hAAAA_0000);
    icache_rsp_valid = 1'b1;
    icache_rsp_tag   = 2'd1;
    icache_rsp_data  = 32'hBBBB_1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_rsp_ready", 128'(icache_rsp_ready), 128'd0);
      check("stall_valid", 128'(ifetch_rsp_valid), 128'd1);
      check("stall_hold", 128'({ifetch_rsp_wid, ifetch_rsp_data}), 128'({2'd0, 32'hAAAA_0000}));
      step();
    end
    check("stall_pending", 128'(pending_count), 128'd1);
    ifetch_rsp_ready = 1'b1;
    offer_rsp(1, 32'hBBBB_1111);
    step();
    step();

    // Icache not ready: request not accepted
    ifetch_req_valid = 1'b1;
    ifetch_req_wid   = 2'd3;
    ifetch_req_PC    = 32'h0000_7000;
    icache_req_ready = 1'b0;
    @(negedge clk);
    check("blocked_req_ready", 128'(ifetch_req_ready), 128'd0);
    check("blocked_icache_valid", 128'(icache_req_valid), 128'd1);
    step();
    check("blocked_pending", 128'(pending_count), 128'd0);
    ifetch_req_valid = 1'b0;
    icache_req_ready = 1'b1;

    // Same-cycle response and reissue on warp 2
    issue_req(2, 32'h0000_A000, 4'b0011, 44'h000_0000_0300);
    req_and_rsp(2, 32'h0000_B000, 4'b1100, 44'h000_0000_0301, 32'hCAFE_0001);
    check("same_cycle_pending", 128'(pending_count), 128'd1);
    offer_rsp(2, 32'hCAFE_0002);
    check("same_cycle_drained", 128'(pending_count), 128'd0);
    step();
    step();

    // Reset mid-operation
    ifetch_rsp_ready = 1'b0;
    issue_req(0, 32'h0000_C000, 4'b0001, 44'h000_0000_0400);
    issue_req(1, 32'h0000_C004, 4'b0010, 44'h000_0000_0401);
    issue_req(2, 32'h0000_C008, 4'b0100, 44'h000_0000_0402);
    issue_req(3, 32'h0000_C00C, 4'b1000, 44'h000_0000_0403);
    offer_rsp(3, 32'hF00D_0003);
    check("pre_reset_pending", 128'(pending_count), 128'd3);
    check("pre_reset_valid", 128'(ifetch_rsp_valid), 128'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_reset_pending", 128'(pending_count), 128'd0);
    check("post_reset_valid", 128'(ifetch_rsp_valid), 128'd0);
    check("post_reset_busy", 128'(busy), 128'd0);
    ifetch_rsp_ready = 1'b1;
    repeat (3) step();

    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vx_ifetch_stage.md
# vx_ifetch_stage

Instruction fetch responder sitting between the warp scheduler and the instruction cache. It accepts fetch requests (wid, PC, tmask, uuid) from the scheduler, issues word reads to the icache tagged by warp id, and pairs each returning instruction word with the stored request metadata. The paired result is driven to the decode stage through a registered, back-pressurable output.

## Interface
- CORE_ID, 0, core index; not used in logic.
- NUM_WARPS, 4, warps per core (power of 2, ≥2); NW_BITS = log2(NUM_WARPS).
- NUM_THREADS, 4, threads per warp.
- UUID_BITS, 44, instruction uuid width.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high.
- ifetch_req_valid  in  1  scheduler request valid.
- ifetch_req_ready  out  1  request accepted this cycle.
- ifetch_req_wid  in  NW_BITS  warp id.
- ifetch_req_PC  in  32  byte PC.
- ifetch_req_tmask  in  NUM_THREADS  thread mask.
- ifetch_req_uuid  in  UUID_BITS  instruction uuid.
- icache_req_valid  out  1  icache read valid.
- icache_req_ready  in  1  icache accepts.
- icache_req_addr  out  30  word address = PC[31:2].
- icache_req_tag  out  NW_BITS  = wid.
- icache_rsp_valid  in  1  icache response valid.
- icache_rsp_ready  out  1  response accepted.
- icache_rsp_data  in  32  instruction word.
- icache_rsp_tag  in  NW_BITS  warp id of response.
- ifetch_rsp_valid  out  1  decode output valid.
- ifetch_rsp_ready  in  1  decode accepts.
- ifetch_rsp_wid / _PC / _tmask / _uuid / _data  out  NW_BITS / 32 / NUM_THREADS / UUID_BITS / 32  paired result.
- pending_count  out  NW_BITS+1  outstanding icache requests.
- busy  out  1  pending_count != 0 or ifetch_rsp_valid.

## Operation
- Request path (combinational pass-through): icache_req_valid = ifetch_req_valid; ifetch_req_ready = icache_req_ready; addr = PC[31:2]; tag = wid.
- req_fire = ifetch_req_valid & ifetch_req_ready: write {PC, tmask, uuid} into metadata table entry [wid]; set pending_mask[wid].
- At most one outstanding fetch per warp (scheduler stalls a warp until decode). req_fire with pending_mask[wid]=1 is a protocol error: simulation assertion; entry is overwritten.
- PC[1:0] != 0 on req_fire: simulation assertion; address truncated.
- Response path: icache_rsp_ready = !ifetch_rsp_valid | ifetch_rsp_ready. rsp_fire loads output register with {tag, table[tag], data}, clears pending_mask[tag]. Responses may return in any order; pairing is by tag only.
- rsp_fire with pending_mask[tag]=0: simulation assertion; output still produced from stale entry.
- Output register: ifetch_rsp_valid set on rsp_fire; cleared when ifetch_rsp_ready and no new rsp_fire; holds data stable while valid & !ready.
- pending_count = popcount(pending_mask); range 0..NUM_WARPS.
- Simultaneous req_fire and rsp_fire: both applied; same-wid case (rsp clears, req sets) resolves to set with new metadata; table read for rsp uses pre-write contents.

## Timing
- Reset: pending_mask=0, pending_count=0, ifetch_rsp_valid=0, busy=0; table and output data unreset (don't-care). Request outputs follow inputs combinationally.
- Request: zero-cycle pass-through; no added latency.
- Response: rsp_fire in cycle N -> ifetch_rsp_valid in N+1; full throughput (one per cycle) when ifetch_rsp_ready=1.
- Back-pressure: icache_rsp_ready depends combinationally on ifetch_rsp_ready; no combinational path from icache_rsp_valid to ifetch_rsp_*.
- Reset mid-operation: outstanding fetches dropped; icache is reset in the same cycle, so no stale responses arrive afterward.

## Test plan
- Single fetch: req wid=1, PC=0x80000004, tmask=4'b0011 -> icache addr=0x20000001, tag=1; rsp data=0xDEADBEEF in cycle N -> cycle N+1 ifetch_rsp {wid=1, PC=0x80000004, tmask=0011, data=0xDEADBEEF}, pending 1->0.
- Out-of-order: reqs wid 0,1,2,3 back-to-back; rsps tags 2,0,3,1 -> outputs in order 2,0,3,1 with matching PC/uuid; pending_count peaks at 4, returns to 0.
- Output stall: ifetch_rsp_ready=0 for 5 cycles with 2 rsps offered -> first held stable, icache_rsp_ready=0, second delivered after ready rises, nothing lost.
- icache_req_ready=0 -> ifetch_req_ready=0, no table write, pending unchanged.
- Same-cycle rsp tag=2 and new req wid=2 -> output carries old wid-2 metadata; pending_mask[2] stays 1 with new PC.
- Reset asserted with 3 pending and output valid -> next cycle pending_count=0, ifetch_rsp_valid=0, busy=0.
